// File: rtl/breakout_pkg.sv
// Shared constants and BCD helper for the breakout game sequencer.
// The optional best-score register is enabled by BREAKOUT_HISCORE_EN.
package breakout_pkg;

    localparam logic [1:0] ST_NEWGAME = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b01;
    localparam logic [1:0] ST_NEWBALL = 2'b10;
    localparam logic [1:0] ST_OVER    = 2'b11;

    localparam logic [7:0] BCD_MAX = 8'h99;

    localparam int unsigned DEF_LIVES        = 3;
    localparam int unsigned DEF_TIMER_W      = 28;
    localparam int unsigned DEF_NEWBALL_WAIT = 50_000_000;
    localparam int unsigned DEF_OVER_WAIT    = 200_000_000;

    typedef enum logic [1:0] {
        S_NEWGAME = ST_NEWGAME,
        S_PLAY    = ST_PLAY,
        S_NEWBALL = ST_NEWBALL,
        S_OVER    = ST_OVER
    } state_t;

    function automatic logic [7:0] bcd_sat_inc(input logic [7:0] v);
        logic [7:0] r;
        r = {v[7:4], v[3:0] + 4'd1};
        if (v == BCD_MAX) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_sat_inc2.sv
// Two-digit BCD counter that saturates at 99; clr wins over inc.
module bcd_sat_inc2
    import breakout_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= 8'h00;
        end else if (clr) begin
            r_q <= 8'h00;
        end else if (inc) begin
            r_q <= bcd_sat_inc(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: newgame/play/newball/over FSM, lives, BCD score.
// Define BREAKOUT_HISCORE_EN to keep a best-score register in hi_score.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int unsigned LIVES        = DEF_LIVES,
    parameter int unsigned TIMER_W      = DEF_TIMER_W,
    parameter int unsigned NEWBALL_WAIT = DEF_NEWBALL_WAIT,
    parameter int unsigned OVER_WAIT    = DEF_OVER_WAIT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic       cleared,
    output logic [1:0] state,
    output logic       gra_still,
    output logic [1:0] ball_cnt,
    output logic [7:0] score,
    output logic       win,
    output logic [7:0] hi_score
);

    localparam logic [1:0]         LIVES_B = 2'(LIVES);
    localparam logic [TIMER_W-1:0] NB_LOAD = TIMER_W'(NEWBALL_WAIT);
    localparam logic [TIMER_W-1:0] OV_LOAD = TIMER_W'(OVER_WAIT);
    localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);

    state_t             r_state;
    logic               r_still;
    logic [1:0]         r_ball_cnt;
    logic               r_win;
    logic [TIMER_W-1:0] r_timer;
    logic               r_start_q;
    logic               r_hit_q;
    logic               r_miss_q;
    logic               r_clr_q;

    logic       w_start_ev;
    logic       w_hit_ev;
    logic       w_miss_ev;
    logic       w_clr_ev;
    logic       w_score_clr;
    logic       w_score_inc;
    logic [7:0] w_score;

    assign w_start_ev = start & ~r_start_q;
    assign w_hit_ev   = hit & ~r_hit_q;
    assign w_miss_ev  = miss & ~r_miss_q;
    assign w_clr_ev   = cleared & ~r_clr_q;

    assign w_score_clr = (r_state == S_NEWGAME) & w_start_ev;
    assign w_score_inc = (r_state == S_PLAY) & w_hit_ev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start_q <= 1'b0;
            r_hit_q   <= 1'b0;
            r_miss_q  <= 1'b0;
            r_clr_q   <= 1'b0;
        end else begin
            r_start_q <= start;
            r_hit_q   <= hit;
            r_miss_q  <= miss;
            r_clr_q   <= cleared;
        end
    end

    bcd_sat_inc2 u_score (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_score_clr),
        .inc  (w_score_inc),
        .q    (w_score)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_NEWGAME;
            r_still    <= 1'b1;
            r_ball_cnt <= LIVES_B;
            r_win      <= 1'b0;
            r_timer    <= '0;
        end else begin
            unique case (r_state)
                S_NEWGAME: begin
                    if (w_start_ev) begin
                        r_state    <= S_PLAY;
                        r_still    <= 1'b0;
                        r_ball_cnt <= LIVES_B;
                        r_win      <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (w_clr_ev) begin
                        r_win   <= 1'b1;
                        r_timer <= OV_LOAD;
                        r_state <= S_OVER;
                        r_still <= 1'b1;
                    end else if (w_miss_ev) begin
                        r_still <= 1'b1;
                        if (r_ball_cnt > 2'd1) begin
                            r_ball_cnt <= r_ball_cnt - 2'd1;
                            r_timer    <= NB_LOAD;
                            r_state    <= S_NEWBALL;
                        end else begin
                            r_ball_cnt <= 2'd0;
                            r_timer    <= OV_LOAD;
                            r_state    <= S_OVER;
                        end
                    end
                end
                S_NEWBALL: begin
                    // early launch presses are dropped, not queued
                    if (w_start_ev && r_timer == '0) begin
                        r_state <= S_PLAY;
                        r_still <= 1'b0;
                    end else if (r_timer != '0) begin
                        r_timer <= r_timer - T_ONE;
                    end
                end
                S_OVER: begin
                    if (r_timer <= T_ONE) begin
                        r_timer <= '0;
                        r_state <= S_NEWGAME;
                    end else begin
                        r_timer <= r_timer - T_ONE;
                    end
                end
                default: begin
                    r_state <= S_NEWGAME;
                    r_still <= 1'b1;
                end
            endcase
        end
    end

`ifdef BREAKOUT_HISCORE_EN
    logic [7:0] r_hi;
    logic       w_to_over;
    logic [7:0] w_score_nxt;

    // compare against the score including a hit on the final edge
    assign w_score_nxt = w_score_inc ? bcd_sat_inc(w_score) : w_score;
    assign w_to_over   = (r_state == S_PLAY) &
                         (w_clr_ev | (w_miss_ev & (r_ball_cnt <= 2'd1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hi <= 8'h00;
        end else if (w_to_over && (w_score_nxt > r_hi)) begin
            r_hi <= w_score_nxt;
        end
    end

    assign hi_score = r_hi;
`else
    assign hi_score = 8'h00;
`endif

    assign state     = r_state;
    assign gra_still = r_still;
    assign ball_cnt  = r_ball_cnt;
    assign score     = w_score;
    assign win       = r_win;

endmodule
